// File: rtl/series_ctrl_fsm.sv
// Control sequencer for the series-expansion datapath: pops an op packet, steps the
// coefficient ROM and an NUM_STG-deep pipeline through res terms, then drains.
module series_ctrl_fsm #(
    parameter int NUM_MODES = 3,
    parameter int RES_WIDTH = 8,
    parameter int NUM_STG   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pkt_valid,
    input  logic [NUM_MODES-1:0] mode,
    input  logic [RES_WIDTH-1:0] res,
    input  logic                 abort,
    output logic                 fifo_rd,
    output logic                 rd_coeff,
    output logic [RES_WIDTH-1:0] coeff_idx,
    output logic                 op,
    output logic [NUM_STG-1:0]   stg_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE, READ, DECODE, RUN, DRAIN, DONE, ERR
    } state_t;

    localparam int DRN_W = (NUM_STG > 2) ? $clog2(NUM_STG - 1) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((NUM_STG > 1) ? NUM_STG - 2 : 0);

    state_t               state;
    logic [RES_WIDTH-1:0] term_cnt;
    logic [RES_WIDTH-1:0] res_q;
    logic [RES_WIDTH-1:0] term_nxt;
    logic [DRN_W-1:0]     drain_cnt;
    logic                 alt_q;     // latched mode is SIN or COS
    logic                 mode_ok;
    logic                 pkt_ok;

    assign mode_ok  = (mode != '0) && ((mode & (mode - 1'b1)) == '0);
    assign pkt_ok   = mode_ok && (res >= RES_WIDTH'(2));
    assign term_nxt = term_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            term_cnt  <= '0;
            res_q     <= '0;
            alt_q     <= 1'b0;
            drain_cnt <= '0;
            fifo_rd   <= 1'b0;
            rd_coeff  <= 1'b0;
            coeff_idx <= '0;
            op        <= 1'b0;
            stg_en    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: every registered output gets a default here, so pulses last exactly
            // one cycle and each state only states what it raises.
            fifo_rd   <= 1'b0;
            rd_coeff  <= 1'b0;
            coeff_idx <= '0;
            op        <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            stg_en    <= stg_en << 1;

            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                term_cnt  <= '0;
                drain_cnt <= '0;
                stg_en    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pkt_valid) begin
                            state   <= READ;
                            fifo_rd <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    READ: state <= DECODE;
                    DECODE: begin
                        res_q <= res;
                        alt_q <= mode[1] | mode[2];
                        if (!pkt_ok) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state     <= RUN;
                            term_cnt  <= '0;
                            rd_coeff  <= 1'b1;
                            stg_en[0] <= 1'b1;
                        end
                    end
                    RUN: begin
                        term_cnt <= term_nxt;
                        if (term_cnt == res_q - 1'b1) begin
                            drain_cnt <= '0;
                            if (NUM_STG == 1) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            rd_coeff  <= 1'b1;
                            coeff_idx <= term_nxt;
                            op        <= alt_q & term_nxt[0];
                            stg_en[0] <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    DONE, ERR: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_series_ctrl_fsm.sv
// Bench for series_ctrl_fsm: three instances (NUM_STG = 1, 2, 3) on shared stimulus,
// checked cycle by cycle against a timeline model derived from the packet rules.
module tb_series_ctrl_fsm;

    typedef struct packed {
        logic       fifo_rd;
        logic       rd_coeff;
        logic [7:0] coeff_idx;
        logic       op;
        logic [2:0] stg_en;
        logic       busy;
        logic       done;
        logic       err;
    } out_t;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] res;
        logic       exp_err;
        int         exp_evt;   // cycle of done/err pulse on the NUM_STG=2 instance
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pkt_valid, abort;
    logic [2:0] mode;
    logic [7:0] res;

    logic       fifo_rd1, rd_coeff1, op1, busy1, done1, err1;
    logic [7:0] coeff_idx1;
    logic [0:0] stg_en1;
    logic       fifo_rd2, rd_coeff2, op2, busy2, done2, err2;
    logic [7:0] coeff_idx2;
    logic [1:0] stg_en2;
    logic       fifo_rd3, rd_coeff3, op3, busy3, done3, err3;
    logic [7:0] coeff_idx3;
    logic [2:0] stg_en3;

    series_ctrl_fsm #(.NUM_MODES(3), .RES_WIDTH(8), .NUM_STG(1)) d1 (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .mode(mode), .res(res), .abort(abort),
        .fifo_rd(fifo_rd1), .rd_coeff(rd_coeff1), .coeff_idx(coeff_idx1), .op(op1),
        .stg_en(stg_en1), .busy(busy1), .done(done1), .err(err1));
    series_ctrl_fsm #(.NUM_MODES(3), .RES_WIDTH(8), .NUM_STG(2)) d2 (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .mode(mode), .res(res), .abort(abort),
        .fifo_rd(fifo_rd2), .rd_coeff(rd_coeff2), .coeff_idx(coeff_idx2), .op(op2),
        .stg_en(stg_en2), .busy(busy2), .done(done2), .err(err2));
    series_ctrl_fsm #(.NUM_MODES(3), .RES_WIDTH(8), .NUM_STG(3)) d3 (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .mode(mode), .res(res), .abort(abort),
        .fifo_rd(fifo_rd3), .rd_coeff(rd_coeff3), .coeff_idx(coeff_idx3), .op(op3),
        .stg_en(stg_en3), .busy(busy3), .done(done3), .err(err3));

    out_t o1, o2, o3;
    assign o1 = {fifo_rd1, rd_coeff1, coeff_idx1, op1, 2'b00, stg_en1, busy1, done1, err1};
    assign o2 = {fifo_rd2, rd_coeff2, coeff_idx2, op2, 1'b0, stg_en2, busy2, done2, err2};
    assign o3 = {fifo_rd3, rd_coeff3, coeff_idx3, op3, stg_en3, busy3, done3, err3};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int c, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected outputs in cycle c after a packet accepted at edge 0 (READ in cycle 1).
    function automatic out_t exp_out(input int c, input logic [2:0] m, input int r, input int nstg);
        out_t e;
        bit   legal;
        bit   alt;
        e     = '0;
        legal = (m == 3'b001 || m == 3'b010 || m == 3'b100) && r >= 2;
        alt   = m[1] | m[2];
        if (c == 1) e.fifo_rd = 1'b1;
        if (c >= 1 && c <= 2) e.busy = 1'b1;
        if (!legal) begin
            if (c == 3) begin
                e.err  = 1'b1;
                e.busy = 1'b1;
            end
        end else begin
            if (c >= 3 && c <= 2 + r) begin
                e.rd_coeff  = 1'b1;
                e.coeff_idx = 8'(c - 3);
                e.op        = alt && ((c - 3) % 2 == 1);
            end
            for (int k = 0; k < nstg; k++)
                if (c >= 3 + k && c <= 2 + r + k) e.stg_en[k] = 1'b1;
            if (c >= 3 && c <= 2 + r + nstg) e.busy = 1'b1;
            if (c == 2 + r + nstg) e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic check_idle(input string name);
        check({name, " d1"}, 0, o1, '0);
        check({name, " d2"}, 0, o2, '0);
        check({name, " d3"}, 0, o3, '0);
    endtask

    // Called one step after an edge ("cycle 0"); mode/res are only valid in cycle 2.
    task automatic run_packet(input logic [2:0] m, input logic [7:0] r, input int abort_c,
                              input bit abort_idle, output int evt_cyc, output logic evt_err);
        int   last;
        out_t e1, e2, e3;
        last      = int'(r) + 7;
        evt_cyc   = -1;
        evt_err   = 1'b0;
        pkt_valid = 1'b1;
        abort     = abort_idle;
        mode      = 3'($urandom);
        res       = 8'($urandom);
        @(posedge clk); #1;
        for (int c = 1; c <= last; c++) begin
            pkt_valid = 1'b0;
            abort     = (c == abort_c);
            if (c == 2) begin
                mode = m;
                res  = r;
            end else begin
                mode = 3'($urandom);
                res  = 8'($urandom);
            end
            if (abort_c > 0 && c > abort_c) begin
                e1 = '0; e2 = '0; e3 = '0;
            end else begin
                e1 = exp_out(c, m, int'(r), 1);
                e2 = exp_out(c, m, int'(r), 2);
                e3 = exp_out(c, m, int'(r), 3);
            end
            check("pkt d1", c, o1, e1);
            check("pkt d2", c, o2, e2);
            check("pkt d3", c, o3, e3);
            if (evt_cyc < 0 && (o2.done || o2.err)) begin
                evt_cyc = c;
                evt_err = o2.err;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int   evt;
        logic er;
        out_t e;

        vecs[0] = '{3'b001, 8'd4,   1'b0, 8};
        vecs[1] = '{3'b010, 8'd5,   1'b0, 9};
        vecs[2] = '{3'b100, 8'd5,   1'b0, 9};
        vecs[3] = '{3'b011, 8'd4,   1'b1, 3};
        vecs[4] = '{3'b001, 8'd1,   1'b1, 3};
        vecs[5] = '{3'b000, 8'd3,   1'b1, 3};
        vecs[6] = '{3'b001, 8'd2,   1'b0, 6};
        vecs[7] = '{3'b010, 8'd2,   1'b0, 6};
        vecs[8] = '{3'b100, 8'd0,   1'b1, 3};
        vecs[9] = '{3'b001, 8'd255, 1'b0, 259};

        rst_n = 1'b0; pkt_valid = 1'b0; abort = 1'b0; mode = '0; res = '0;
        #2;
        check_idle("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("post reset");

        for (int i = 0; i < 10; i++) begin
            run_packet(vecs[i].mode, vecs[i].res, 0, 1'b0, evt, er);
            check_int($sformatf("vec%0d evt cycle", i), evt, vecs[i].exp_evt);
            check_int($sformatf("vec%0d evt is err", i), int'(er), int'(vecs[i].exp_err));
        end

        // abort in RUN while coeff_idx=2, then a normal packet
        run_packet(3'b010, 8'd6, 5, 1'b0, evt, er);
        check_int("abort run no done", evt, -1);
        run_packet(3'b100, 8'd3, 0, 1'b0, evt, er);
        check_int("after abort evt", evt, 7);
        // abort during READ (packet lost), during DRAIN, and abort in IDLE (ignored)
        run_packet(3'b001, 8'd4, 1, 1'b0, evt, er);
        run_packet(3'b001, 8'd2, 5, 1'b0, evt, er);
        run_packet(3'b010, 8'd3, 0, 1'b1, evt, er);
        check_int("idle abort ignored", evt, 7);

        // back-to-back with pkt_valid held: checked on the NUM_STG=3 instance
        pkt_valid = 1'b1; mode = 3'b001; res = 8'd3;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            pkt_valid = (c <= 17);
            e = (c <= 9) ? exp_out(c, 3'b001, 3, 3) : exp_out(c - 9, 3'b001, 3, 3);
            check("b2b d3", c, o3, e);
            @(posedge clk); #1;
        end
        pkt_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_idle("b2b flush");

        // asynchronous reset mid-RUN
        pkt_valid = 1'b1; mode = 3'b010; res = 8'd8;
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre reset d2", 5, o2, exp_out(5, 3'b010, 8, 2));
        rst_n = 1'b0;
        #1;
        check_idle("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            check_idle("held idle");
            @(posedge clk); #1;
        end
        run_packet(3'b001, 8'd3, 0, 1'b0, evt, er);
        check_int("after reset evt", evt, 7);

        // randomized packets, optional random abort
        for (int i = 0; i < 30; i++) begin
            logic [2:0] m;
            logic [7:0] r;
            int         ac;
            m  = 3'($urandom_range(0, 7));
            r  = 8'($urandom_range(0, 12));
            ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(r) + 5)) : 0;
            run_packet(m, r, ac, 1'b0, evt, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/series_ctrl_fsm.md
# series_ctrl_fsm

Parametrised control sequencer for the series-expansion datapath. It pops one operation packet from the input FIFO, decodes the one-hot mode and the term count (resolution), and then steps the coefficient ROM and an N-stage compute pipeline through `res` terms. For alternating series it drives add/subtract per term, then drains the pipeline and signals completion. It sits between the op-packet FIFO and the multiply/accumulate stages, and supports illegal-packet rejection and synchronous abort.

## Interface
- NUM_MODES, 3, width of one-hot mode field; bit0 = EXP, bit1 = SIN, bit2 = COS, higher bits = non-alternating series
- RES_WIDTH, 8, width of res, term counter and coeff_idx
- NUM_STG, 2, number of pipeline stages enabled (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pkt_valid  in  1  FIFO non-empty
- mode  in  NUM_MODES  packet mode, valid the cycle after fifo_rd
- res  in  RES_WIDTH  number of terms, valid the cycle after fifo_rd
- abort  in  1  synchronous cancel of current packet
- fifo_rd  out  1  one-cycle FIFO pop
- rd_coeff  out  1  coefficient ROM read enable
- coeff_idx  out  RES_WIDTH  coefficient/term index
- op  out  1  0 = ADD, 1 = SUB for accumulator
- stg_en  out  NUM_STG  per-stage enable; bit k lags bit 0 by k cycles
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-packet pulse

## Operation
- States: IDLE, READ, DECODE, RUN, DRAIN, DONE, ERR.
- IDLE: pkt_valid=1 -> READ.
- READ: fifo_rd=1 for exactly one cycle -> DECODE.
- DECODE: mode and res are latched into mode_q and res_q. If mode is not exactly one-hot, or res<2 -> ERR. Otherwise term_cnt=0 -> RUN.
- RUN:
  - rd_coeff=1, coeff_idx=term_cnt, stg_en[0]=1; term_cnt increments each cycle.
  - term_cnt==res_q-1 -> DRAIN, or DONE if NUM_STG==1.
- op in RUN:
  - mode_q bit1 or bit2: op=term_cnt[0], so term 0 is ADD.
  - Any other mode: op=0.
  - Outside RUN: op=0.
- stg_en[k]: flop of stg_en[k-1]. These keep shifting in DRAIN with stg_en[0]=0.
- DRAIN: lasts exactly NUM_STG-1 cycles, counted by a drain counter -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle -> IDLE. The popped packet is discarded; no rd_coeff and no stg_en.
- abort=1 in any state except IDLE:
  - next state is IDLE and the whole stg_en shift register clears on the same edge.
  - term_cnt clears; no done or err is pulsed.
  - abort in IDLE is ignored.
  - abort sampled in READ: the pop has already happened and the packet is lost.
- Arithmetic: term_cnt is RES_WIDTH wide. No wrap is possible because res_q ≥ 2 and the compare is equality with res_q-1.
- Outputs are decoded only from registered state, counters and stg_en flops. There is no combinational path from any input to any output.
- Reset: state=IDLE; term_cnt, drain counter, mode_q, res_q = 0; every output (fifo_rd, rd_coeff, coeff_idx, op, stg_en, busy, done, err) = 0.
- Reset mid-operation returns to IDLE immediately; the packet is lost.

## Timing
- pkt_valid is sampled high in IDLE at edge 0, giving this sequence:
  - READ in cycle 1.
  - DECODE in cycle 2.
  - RUN in cycles 3 .. 2+res.
  - DRAIN in cycles 3+res .. 1+res+NUM_STG.
  - done in cycle 2+res+NUM_STG.
- Illegal packet: err in cycle 3.
- After DONE or ERR, at least one IDLE cycle follows before the next READ. With pkt_valid held high, READ is in cycle 4+res+NUM_STG after the first packet.
- The FIFO provides mode/res one cycle after the fifo_rd cycle; the block samples them in DECODE.
- stg_en[NUM_STG-1] falls in the last DRAIN cycle (the last RUN cycle when NUM_STG=1) and is low in the DONE cycle.

## Test plan
- EXP, mode=001, res=4, NUM_STG=2:
  - fifo_rd high in cycle 1 only; coeff_idx 0,1,2,3 in cycles 3–6; op all 0.
  - stg_en[1] high in cycles 4–7; done in cycle 8; busy high in cycles 1–8.
- SIN, mode=010, res=5: op sequence 0,1,0,1,0 in cycles 3–7; COS (100) gives the same sequence.
- Illegal packets, mode=011 res=4, then mode=001 res=1: each gives err in cycle 3, rd_coeff never high, IDLE in cycle 4, done never high.
- abort during RUN, asserted while coeff_idx=2:
  - next cycle is IDLE with stg_en=0, busy=0 and op=0.
  - no done; a following packet runs normally.
- Back-to-back, pkt_valid held high, two EXP packets with res=3, NUM_STG=3: first done in cycle 8, IDLE in cycle 9, second fifo_rd in cycle 10.
- rst_n driven low mid-RUN (async, between edges): all outputs 0 immediately; after release the block stays IDLE until pkt_valid.
